ex_mem_reg: RTL and testbench
=============================

# ex_mem_reg

Execute-stage result register and multi-cycle sequencer that sits directly downstream of the ALU. It captures the ALU result, branch decision and instruction tags into the EX/MEM pipeline register. It stalls the ID/EX register while a multiplier or divider operation is in flight, and drives the ALU's `ready_flag` so that mul/div results are consumed exactly once. Flush and backpressure from MEM are resolved here.

## Interface
Parameters:
- `XLEN`, 64: datapath width.
- `REG_ADDR_W`, 5: destination register index width.

Ports:
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `flush_flag` input 1: kill the instruction currently in EX.
- `ID_EX_reg_decode_valid` input 1: ID/EX register holds a valid instruction.
- `ID_EX_reg_mul_valid`, `ID_EX_reg_div_valid`, `ID_EX_reg_trap_valid` input 1 each: op class.
- `ID_EX_reg_rd` input REG_ADDR_W: destination register.
- `ID_EX_reg_rd_wen` input 1: writes rd.
- `ID_EX_reg_pc` input XLEN: instruction PC.
- `alu_res` input XLEN: ALU `res`.
- `alu_o_valid` input 1: ALU mul/div result valid.
- `alu_branch_flag` input 1: ALU branch decision.
- `MEM_EX_ready` input 1: MEM accepts EX/MEM contents this cycle.
- `EX_ID_ready` output 1: EX consumes the ID/EX instruction this cycle.
- `ready_flag` output 1: to ALU mul/div `o_ready`.
- `EX_MEM_reg_valid` output 1; `EX_MEM_reg_res` output XLEN; `EX_MEM_reg_rd` output REG_ADDR_W; `EX_MEM_reg_rd_wen` output 1; `EX_MEM_reg_pc` output XLEN; `EX_MEM_reg_branch` output 1; `EX_MEM_reg_trap` output 1.
- `ex_stall_cnt` output 64: present only with EX_STALL_CNT_EN.

## Operation
Definitions:
- `out_free = !EX_MEM_reg_valid | MEM_EX_ready`.
- `multi = (mul_valid | div_valid) & !trap_valid`.

FSM has two states, IDLE and WAIT.

IDLE:
- `decode_valid & !multi & out_free & !flush_flag`: capture (result = `alu_res`, branch = `alu_branch_flag`, trap = `trap_valid`, tags). `EX_ID_ready=1`.
- `decode_valid & multi & !flush_flag`: go to WAIT. `EX_ID_ready=0`. No capture.
- `!out_free`: `EX_ID_ready=0`. Hold.

WAIT:
- `ready_flag = out_free & !flush_flag`.
- `alu_o_valid & ready_flag`: capture `alu_res`, `EX_ID_ready=1`, go to IDLE.
- Otherwise hold with `EX_ID_ready=0`. ID/EX must stay stable.

In IDLE, `ready_flag=0`.

Output register:
- If `MEM_EX_ready & EX_MEM_reg_valid` and there is no capture in the same cycle, `EX_MEM_reg_valid` goes to 0.
- A capture sets valid to 1. A capture and a drain in the same cycle keep valid at 1 with the new contents.
- Data fields update only on capture.

Flush:
- Forces FSM to IDLE. Suppresses capture and `EX_ID_ready` that cycle. Forces `ready_flag=0`.
- The mul/div unit is flushed by the ALU's own `flush_flag`.
- `EX_MEM_reg_valid` and its contents are NOT cleared, because they hold an older instruction.

Trap instructions never enter WAIT and pass through as single-cycle ops with `EX_MEM_reg_trap=1`.

## Timing
- Reset values: FSM IDLE; `EX_MEM_reg_valid`, `EX_MEM_reg_rd_wen`, `EX_MEM_reg_branch`, `EX_MEM_reg_trap`, `EX_ID_ready`, `ready_flag` are 0; data/tag registers are 0; `ex_stall_cnt` is 0.
- Reset mid-WAIT discards the in-flight op.
- Single-cycle op latency: accepted in cycle N, visible on EX_MEM outputs in cycle N+1.
- Multi-cycle op: WAIT is entered at edge N+1. The result is visible the cycle after the `alu_o_valid & ready_flag` cycle.
- `EX_ID_ready` and `ready_flag` are combinational from state, inputs and the output valid bit. There is no combinational path from `alu_res`.
- `alu_o_valid` while in IDLE is ignored.

## Configuration
- `EX_STALL_CNT_EN`: when defined, `ex_stall_cnt` increments once per cycle while the FSM is in WAIT or while `decode_valid & !out_free`. It saturates at all-ones and is cleared only by reset.
- Without the macro, the port and the counter are absent.

## Structure
- Shared package/define file (`define.v`) holds the FSM state encodings (IDLE=1'b0, WAIT=1'b1) and the `XLEN` and `REG_ADDR_W` defaults.
- One sub-module, `stall_counter`: a saturating 64-bit counter with an enable, instantiated only under `EX_STALL_CNT_EN`.

## Test plan
- Single-cycle op: `decode_valid=1`, `alu_res=0x1234`, `rd=5`, `MEM_EX_ready=1` → same-cycle `EX_ID_ready=1`; next cycle `EX_MEM_reg_valid=1`, `res=0x1234`, `rd=5`.
- Divide: `div_valid=1`, `alu_o_valid` asserted 10 cycles later with `res=7` → `EX_ID_ready=0` for 10 cycles; `ready_flag=1` during WAIT; `res=7` is captured once; FSM returns to IDLE.
- Backpressure: EX/MEM holds a valid result, `MEM_EX_ready=0` for 3 cycles, mul completes → `ready_flag=0` and no capture until `MEM_EX_ready=1`; the old result stays stable meanwhile.
- Flush in WAIT: `flush_flag=1` on the 2nd WAIT cycle → FSM goes to IDLE, no capture, `EX_MEM_reg_valid` is unchanged; a later stale `alu_o_valid` is ignored.
- Simultaneous drain and capture: `EX_MEM_reg_valid=1`, `MEM_EX_ready=1`, new single-cycle op → valid stays 1 and the new data appears next cycle.
- Trap with `mul_valid=1` and `trap_valid=1` → single-cycle capture with `EX_MEM_reg_trap=1`, no WAIT; with `EX_STALL_CNT_EN`, the counter equals the number of WAIT cycles after the divide test.

Source files
------------

// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared definitions for the EX/MEM result register slice.
//   - Datapath / register-index width defaults (XLEN, REG_ADDR_W).
//   - Sequencer state encodings (IDLE / WAIT).
//   - Width of the optional stall counter (enabled by EX_STALL_CNT_EN).
package ex_mem_reg_pkg;

  localparam int unsigned DefaultXlen     = 64;
  localparam int unsigned DefaultRegAddrW = 5;
  localparam int unsigned StallCntW       = 64;

  // Sequencer states, kept as plain constants for legacy compatibility.
  localparam logic StIdle = 1'b0;
  localparam logic StWait = 1'b1;

endpackage

// File: rtl/ex_mem_reg_stall_counter.sv
// stall_counter: saturating up-counter with enable, cleared only by reset.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset
//   en_i    - count enable (one increment per enabled cycle)
//   cnt_o   - current count, sticks at all-ones
module stall_counter #(
  parameter int unsigned Width = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != {Width{1'b1}})) begin
      cnt_d = cnt_q + {{(Width-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register plus mul/div sequencer behind the ALU.
// Captures ALU result, branch decision and instruction tags; holds ID/EX while a
// mul/div op is in flight and drives the ALU ready_flag so each mul/div result
// is consumed exactly once. Resolves flush and MEM backpressure.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   flush_flag                 - kill the instruction currently in EX
//   ID_EX_reg_*                - instruction in ID/EX (valid, op class, rd, pc)
//   alu_res/alu_o_valid/alu_branch_flag - ALU result, mul/div valid, branch
//   MEM_EX_ready               - MEM takes EX/MEM contents this cycle
//   EX_ID_ready                - EX consumes the ID/EX instruction this cycle
//   ready_flag                 - mul/div result accept strobe to the ALU
//   EX_MEM_reg_*               - EX/MEM register contents
//   ex_stall_cnt               - stall cycle count, only with EX_STALL_CNT_EN
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int unsigned XLEN       = DefaultXlen,
  parameter int unsigned REG_ADDR_W = DefaultRegAddrW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_flag,
  input  logic                  ID_EX_reg_decode_valid,
  input  logic                  ID_EX_reg_mul_valid,
  input  logic                  ID_EX_reg_div_valid,
  input  logic                  ID_EX_reg_trap_valid,
  input  logic [REG_ADDR_W-1:0] ID_EX_reg_rd,
  input  logic                  ID_EX_reg_rd_wen,
  input  logic [XLEN-1:0]       ID_EX_reg_pc,
  input  logic [XLEN-1:0]       alu_res,
  input  logic                  alu_o_valid,
  input  logic                  alu_branch_flag,
  input  logic                  MEM_EX_ready,
  output logic                  EX_ID_ready,
  output logic                  ready_flag,
  output logic                  EX_MEM_reg_valid,
  output logic [XLEN-1:0]       EX_MEM_reg_res,
  output logic [REG_ADDR_W-1:0] EX_MEM_reg_rd,
  output logic                  EX_MEM_reg_rd_wen,
  output logic [XLEN-1:0]       EX_MEM_reg_pc,
  output logic                  EX_MEM_reg_branch,
  output logic                  EX_MEM_reg_trap
`ifdef EX_STALL_CNT_EN
  ,
  output logic [StallCntW-1:0]  ex_stall_cnt
`endif
);

  logic state_q, state_d;
  logic out_free, multi, capture, wait_ready;

  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       res_q, pc_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  rd_wen_q, branch_q, trap_q;

  // EX/MEM can take new contents if empty or being drained this cycle.
  assign out_free = ~valid_q | MEM_EX_ready;
  // Traps never wait on the mul/div unit even if tagged mul/div.
  assign multi = (ID_EX_reg_mul_valid | ID_EX_reg_div_valid) & ~ID_EX_reg_trap_valid;

  always_comb begin
    state_d    = state_q;
    capture    = 1'b0;
    wait_ready = 1'b0;
    case (state_q)
      StIdle: begin
        if (ID_EX_reg_decode_valid && !flush_flag) begin
          if (multi) begin
            state_d = StWait;
          end else if (out_free) begin
            capture = 1'b1;
          end
        end
      end
      StWait: begin
        wait_ready = out_free & ~flush_flag;
        if (flush_flag) begin
          state_d = StIdle;
        end else if (alu_o_valid && wait_ready) begin
          capture = 1'b1;
          state_d = StIdle;
        end
      end
    endcase
  end

  assign EX_ID_ready = capture;
  assign ready_flag  = wait_ready;

  // Capture wins over drain; flush never clears the older EX/MEM entry.
  always_comb begin
    valid_d = valid_q;
    if (capture) begin
      valid_d = 1'b1;
    end else if (MEM_EX_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q    <= '0;
      pc_q     <= '0;
      rd_q     <= '0;
      rd_wen_q <= 1'b0;
      branch_q <= 1'b0;
      trap_q   <= 1'b0;
    end else if (capture) begin
      res_q    <= alu_res;
      pc_q     <= ID_EX_reg_pc;
      rd_q     <= ID_EX_reg_rd;
      rd_wen_q <= ID_EX_reg_rd_wen;
      branch_q <= alu_branch_flag;
      trap_q   <= ID_EX_reg_trap_valid;
    end
  end

  assign EX_MEM_reg_valid  = valid_q;
  assign EX_MEM_reg_res    = res_q;
  assign EX_MEM_reg_rd     = rd_q;
  assign EX_MEM_reg_rd_wen = rd_wen_q;
  assign EX_MEM_reg_pc     = pc_q;
  assign EX_MEM_reg_branch = branch_q;
  assign EX_MEM_reg_trap   = trap_q;

`ifdef EX_STALL_CNT_EN
  logic stall_en;
  assign stall_en = (state_q == StWait) | (ID_EX_reg_decode_valid & ~out_free);

  stall_counter #(
    .Width(StallCntW)
  ) u_stall_counter (
    .clk_i (clk),
    .rst_ni(rst_n),
    .en_i  (stall_en),
    .cnt_o (ex_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int VW   = 1 + XLEN + RW + 1 + XLEN + 1 + 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush_flag, dv, mul_v, div_v, trap_v, rd_wen, alu_o_valid, alu_br, mem_ready;
  logic [RW-1:0]   rd;
  logic [XLEN-1:0] pc, alu_res;
  logic            EX_ID_ready, ready_flag, o_valid, o_rd_wen, o_branch, o_trap;
  logic [XLEN-1:0] o_res, o_pc;
  logic [RW-1:0]   o_rd;
`ifdef EX_STALL_CNT_EN
  logic [63:0]     ex_stall_cnt;
`endif

  ex_mem_reg #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .flush_flag(flush_flag),
    .ID_EX_reg_decode_valid(dv), .ID_EX_reg_mul_valid(mul_v), .ID_EX_reg_div_valid(div_v),
    .ID_EX_reg_trap_valid(trap_v), .ID_EX_reg_rd(rd), .ID_EX_reg_rd_wen(rd_wen),
    .ID_EX_reg_pc(pc), .alu_res(alu_res), .alu_o_valid(alu_o_valid),
    .alu_branch_flag(alu_br), .MEM_EX_ready(mem_ready), .EX_ID_ready(EX_ID_ready),
    .ready_flag(ready_flag), .EX_MEM_reg_valid(o_valid), .EX_MEM_reg_res(o_res),
    .EX_MEM_reg_rd(o_rd), .EX_MEM_reg_rd_wen(o_rd_wen), .EX_MEM_reg_pc(o_pc),
    .EX_MEM_reg_branch(o_branch), .EX_MEM_reg_trap(o_trap)
`ifdef EX_STALL_CNT_EN
    , .ex_stall_cnt(ex_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: "pending" = a mul/div op is parked in EX awaiting its result.
  bit              m_pending, m_valid, m_wen, m_br, m_trap;
  logic [XLEN-1:0] m_res, m_pc;
  logic [RW-1:0]   m_rd;
  logic [63:0]     m_cnt;
  bit              exp_idr, exp_rdy, obs_idr, obs_rdy;

  function automatic logic [VW-1:0] dut_vec();
    return {o_valid, o_res, o_rd, o_rd_wen, o_pc, o_branch, o_trap};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_valid, m_res, m_rd, m_wen, m_pc, m_br, m_trap};
  endfunction

  task automatic model_reset();
    m_pending = 0; m_valid = 0; m_wen = 0; m_br = 0; m_trap = 0;
    m_res = '0; m_pc = '0; m_rd = '0; m_cnt = '0;
  endtask

  task automatic clear_inputs();
    flush_flag = 0; dv = 0; mul_v = 0; div_v = 0; trap_v = 0; rd = '0; rd_wen = 0;
    pc = '0; alu_res = '0; alu_o_valid = 0; alu_br = 0; mem_ready = 0;
  endtask

  // One clock: sample combinational outputs, predict them, advance the model.
  // Entered at posedge+1 with inputs already driven, returns at posedge+1.
  task automatic step();
    bit slot_free, long_op, take, stalled;
    #2;
    obs_idr   = EX_ID_ready;
    obs_rdy   = ready_flag;
    slot_free = !m_valid || mem_ready;
    long_op   = (mul_v || div_v) && !trap_v;
    stalled   = m_pending || (dv && !slot_free);
    if (m_pending) begin
      exp_rdy = slot_free && !flush_flag;
      take    = alu_o_valid && exp_rdy;
    end else begin
      exp_rdy = 0;
      take    = dv && !long_op && slot_free && !flush_flag;
    end
    exp_idr = take;
    @(posedge clk);
    if (stalled && m_cnt != 64'hFFFF_FFFF_FFFF_FFFF) m_cnt = m_cnt + 1;
    if (take) begin
      m_valid = 1; m_res = alu_res; m_rd = rd; m_wen = rd_wen; m_pc = pc;
      m_br = alu_br; m_trap = trap_v;
    end else if (mem_ready) begin
      m_valid = 0;
    end
    if (flush_flag) m_pending = 0;
    else if (!m_pending && dv && long_op) m_pending = 1;
    else if (m_pending && take) m_pending = 0;
    #1;
  endtask

  task automatic load_entry(input logic [XLEN-1:0] r);
    clear_inputs();
    dv = 1; alu_res = r; rd = RW'($urandom); rd_wen = 1; pc = {$urandom, $urandom};
    mem_ready = 1;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    model_reset();
    #3;
    n_checks++;
    if (dut_vec() !== '0 || EX_ID_ready !== 1'b0 || ready_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got regs=%h idr=%b rdy=%b, want all zero",
               dut_vec(), EX_ID_ready, ready_flag);
    end
`ifdef EX_STALL_CNT_EN
    n_checks++;
    if (ex_stall_cnt !== 64'd0) begin
      n_errors++; $display("FAIL reset_cnt: got %0d want 0", ex_stall_cnt);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_single();
    clear_inputs();
    dv = 1; alu_res = 64'h1234; rd = 5; rd_wen = 1; pc = 64'h80; mem_ready = 1;
    step();
    n_checks++;
    if (obs_idr !== 1'b1) begin
      n_errors++; $display("FAIL single_idr: got %b want 1", obs_idr);
    end
    n_checks++;
    if (o_valid !== 1'b1 || o_res !== 64'h1234 || o_rd !== 5'd5) begin
      n_errors++;
      $display("FAIL single_out: got v=%b res=%h rd=%0d want v=1 res=1234 rd=5",
               o_valid, o_res, o_rd);
    end
  endtask

  task automatic test_divide();
    logic [63:0] cnt0;
`ifdef EX_STALL_CNT_EN
    cnt0 = ex_stall_cnt;
`else
    cnt0 = '0;
`endif
    clear_inputs();
    dv = 1; div_v = 1; rd = 9; rd_wen = 1; pc = 64'h100; mem_ready = 1;
    alu_res = 64'hDEAD;
    for (int i = 0; i < 10; i++) begin
      step();
      n_checks++;
      if (obs_idr !== 1'b0 || obs_rdy !== (i != 0)) begin
        n_errors++;
        $display("FAIL div_wait[%0d]: got idr=%b rdy=%b want idr=0 rdy=%b",
                 i, obs_idr, obs_rdy, (i != 0));
      end
    end
    alu_o_valid = 1; alu_res = 64'd7;
    step();
    n_checks++;
    if (obs_idr !== 1'b1 || obs_rdy !== 1'b1 || o_valid !== 1'b1 || o_res !== 64'd7) begin
      n_errors++;
      $display("FAIL div_done: got idr=%b rdy=%b v=%b res=%h want 1 1 1 7",
               obs_idr, obs_rdy, o_valid, o_res);
    end
    // Stale valid after return to IDLE must not produce a second capture.
    dv = 0; div_v = 0; alu_res = 64'd99;
    step();
    n_checks++;
    if (obs_rdy !== 1'b0 || o_valid !== 1'b0 || o_res !== 64'd7) begin
      n_errors++;
      $display("FAIL div_once: got rdy=%b v=%b res=%h want 0 0 7", obs_rdy, o_valid, o_res);
    end
`ifdef EX_STALL_CNT_EN
    n_checks++;
    if (ex_stall_cnt - cnt0 !== 64'd10) begin
      n_errors++; $display("FAIL div_cnt: got delta %0d want 10", ex_stall_cnt - cnt0);
    end
`endif
  endtask

  task automatic test_backpressure();
    load_entry(64'hAAAA);
    clear_inputs();
    dv = 1; mul_v = 1; rd = 3; mem_ready = 0;
    step();
    alu_o_valid = 1; alu_res = 64'hBBBB;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (obs_rdy !== 1'b0 || obs_idr !== 1'b0 || o_valid !== 1'b1 || o_res !== 64'hAAAA) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got rdy=%b idr=%b v=%b res=%h want 0 0 1 aaaa",
                 i, obs_rdy, obs_idr, o_valid, o_res);
      end
    end
    mem_ready = 1;
    step();
    n_checks++;
    if (obs_rdy !== 1'b1 || obs_idr !== 1'b1 || o_valid !== 1'b1 || o_res !== 64'hBBBB) begin
      n_errors++;
      $display("FAIL bp_release: got rdy=%b idr=%b v=%b res=%h want 1 1 1 bbbb",
               obs_rdy, obs_idr, o_valid, o_res);
    end
  endtask

  task automatic test_flush_wait();
    load_entry(64'hC0DE);
    clear_inputs();
    dv = 1; div_v = 1; mem_ready = 0;
    step();
    step();
    flush_flag = 1; alu_o_valid = 1; alu_res = 64'hBAD;
    step();
    n_checks++;
    if (obs_rdy !== 1'b0 || obs_idr !== 1'b0 || o_valid !== 1'b1 || o_res !== 64'hC0DE) begin
      n_errors++;
      $display("FAIL flush_cycle: got rdy=%b idr=%b v=%b res=%h want 0 0 1 c0de",
               obs_rdy, obs_idr, o_valid, o_res);
    end
    flush_flag = 0; dv = 0; div_v = 0; mem_ready = 1;
    step();
    n_checks++;
    if (obs_rdy !== 1'b0 || obs_idr !== 1'b0 || o_valid !== 1'b0 || o_res !== 64'hC0DE) begin
      n_errors++;
      $display("FAIL flush_stale: got rdy=%b idr=%b v=%b res=%h want 0 0 0 c0de",
               obs_rdy, obs_idr, o_valid, o_res);
    end
    alu_o_valid = 0; dv = 1; alu_res = 64'h5;
    step();
    n_checks++;
    if (obs_idr !== 1'b1) begin
      n_errors++; $display("FAIL flush_idle: got idr=%b want 1", obs_idr);
    end
  endtask

  task automatic test_back_to_back();
    load_entry(64'h1111);
    dv = 1; alu_res = 64'h2222; rd = 17; mem_ready = 1;
    step();
    n_checks++;
    if (obs_idr !== 1'b1 || o_valid !== 1'b1 || o_res !== 64'h2222 || o_rd !== 5'd17) begin
      n_errors++;
      $display("FAIL drain_capture: got idr=%b v=%b res=%h rd=%0d want 1 1 2222 17",
               obs_idr, o_valid, o_res, o_rd);
    end
  endtask

  task automatic test_trap();
    logic [63:0] cnt0;
`ifdef EX_STALL_CNT_EN
    cnt0 = ex_stall_cnt;
`else
    cnt0 = '0;
`endif
    clear_inputs();
    dv = 1; mul_v = 1; trap_v = 1; alu_res = 64'h77; pc = 64'h400; mem_ready = 1;
    step();
    n_checks++;
    if (obs_idr !== 1'b1 || obs_rdy !== 1'b0 || o_valid !== 1'b1 || o_trap !== 1'b1
        || o_res !== 64'h77) begin
      n_errors++;
      $display("FAIL trap: got idr=%b rdy=%b v=%b trap=%b res=%h want 1 0 1 1 77",
               obs_idr, obs_rdy, o_valid, o_trap, o_res);
    end
    clear_inputs(); mem_ready = 1; alu_o_valid = 1;
    step();
    n_checks++;
    if (obs_rdy !== 1'b0 || o_valid !== 1'b0) begin
      n_errors++; $display("FAIL trap_nowait: got rdy=%b v=%b want 0 0", obs_rdy, o_valid);
    end
`ifdef EX_STALL_CNT_EN
    n_checks++;
    if (ex_stall_cnt !== cnt0) begin
      n_errors++; $display("FAIL trap_cnt: got %0d want %0d", ex_stall_cnt, cnt0);
    end
`endif
  endtask

  task automatic test_reset_mid_wait();
    clear_inputs();
    dv = 1; div_v = 1; mem_ready = 1;
    step();
    step();
    rst_n = 0;
    clear_inputs();
    model_reset();
    #5;
    rst_n = 1;
    @(posedge clk); #1;
    alu_o_valid = 1; alu_res = 64'h42; mem_ready = 1;
    step();
    n_checks++;
    if (obs_rdy !== 1'b0 || obs_idr !== 1'b0 || o_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_wait: got rdy=%b idr=%b v=%b want 0 0 0", obs_rdy, obs_idr, o_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if (!m_pending) begin
        dv = ($urandom_range(0, 3) != 0);
        mul_v = ($urandom_range(0, 4) == 0);
        div_v = ($urandom_range(0, 4) == 0);
        trap_v = ($urandom_range(0, 7) == 0);
        rd = RW'($urandom); rd_wen = 1'($urandom); pc = {$urandom, $urandom};
      end
      flush_flag  = ($urandom_range(0, 15) == 0);
      mem_ready   = ($urandom_range(0, 3) != 0);
      alu_o_valid = ($urandom_range(0, 2) == 0);
      alu_br      = 1'($urandom);
      alu_res     = {$urandom, $urandom};
      step();
      n_checks++;
      if (obs_idr !== exp_idr || obs_rdy !== exp_rdy) begin
        n_errors++;
        $display("FAIL rand_comb[%0d]: got idr=%b rdy=%b want idr=%b rdy=%b",
                 i, obs_idr, obs_rdy, exp_idr, exp_rdy);
      end
      n_checks++;
      if (dut_vec() !== model_vec()) begin
        n_errors++;
        $display("FAIL rand_regs[%0d]: got %h want %h", i, dut_vec(), model_vec());
      end
`ifdef EX_STALL_CNT_EN
      n_checks++;
      if (ex_stall_cnt !== m_cnt) begin
        n_errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, ex_stall_cnt, m_cnt);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_divide();
    test_backpressure();
    test_flush_wait();
    test_back_to_back();
    test_trap();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
